uart_cmd_sequencer: RTL

//   Frames and validates 4-byte command packets from the uart_reciever byte stream (i_done/i_data).

---
 rtl/uart_cmd_sequencer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/uart_cmd_sequencer.sv
// Frames 4-byte command packets (SOF, CMD, ARG, CHK) and drives the direction outputs with a timed hold.
// Optional inter-byte timeout is compiled in with `define UART_SEQ_TIMEOUT_EN.
module uart_cmd_sequencer #(
    parameter int unsigned CLKS_PER_MS  = 25000,
    parameter int unsigned HOLD_MS      = 100,
    parameter logic [7:0]  SOF          = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 250000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_done,
    input  logic [7:0] i_data,
    output logic       o_right,
    output logic       o_left,
    output logic       o_up,
    output logic       o_down,
    output logic       o_trigger,
    output logic       o_frame_err,
    output logic       o_busy
);

    localparam int unsigned    PRE_W    = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLKS_PER_MS - 1);
    localparam logic [7:0]     HOLD_DEF = 8'(HOLD_MS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_ARG  = 2'd2,
        S_CHK  = 2'd3
    } state_t;

    state_t           state_q;
    logic [7:0]       cmd_q;
    logic [7:0]       arg_q;
    logic             trig_q;
    logic             err_q;
    logic [3:0]       dir_q;
    logic [7:0]       ms_q;
    logic [PRE_W-1:0] presc_q;

    logic             frame_ok;
    logic             accept;
    logic             gap_expire;
    logic [7:0]       ms_load_d;

    function automatic logic frame_valid(input logic [7:0] cmd, input logic [7:0] arg,
                                         input logic [7:0] chk);
        return (chk == (cmd ^ arg)) && (cmd[7:5] == 3'b000)
            && !(cmd[0] && cmd[1]) && !(cmd[2] && cmd[3]);
    endfunction

    assign frame_ok  = frame_valid(cmd_q, arg_q, i_data);
    assign accept    = i_done && (state_q == S_CHK) && frame_ok;
    assign ms_load_d = (arg_q == 8'd0) ? HOLD_DEF : arg_q;

`ifdef UART_SEQ_TIMEOUT_EN
    localparam int unsigned      GAP_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CLKS - 1);

    logic [GAP_W-1:0] gap_q;

    // A byte arriving in the expiry cycle wins: it is parsed and the gap restarts.
    assign gap_expire = !i_done && (state_q != S_IDLE) && (gap_q == GAP_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            gap_q <= '0;
        end else if (i_done || (state_q == S_IDLE) || gap_expire) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_q + GAP_W'(1);
        end
    end
`else
    // Without the gap counter the parser waits forever; TIMEOUT_CLKS has no effect here.
    assign gap_expire = 1'b0 & (TIMEOUT_CLKS == 0);
`endif

    // Parser: advances only on received bytes; a SOF value after S_IDLE is ordinary data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cmd_q   <= 8'd0;
            arg_q   <= 8'd0;
            trig_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            trig_q <= 1'b0;
            err_q  <= 1'b0;
            if (i_done) begin
                case (state_q)
                    S_IDLE: begin
                        if (i_data == SOF) begin
                            state_q <= S_CMD;
                        end
                    end
                    S_CMD: begin
                        cmd_q   <= i_data;
                        state_q <= S_ARG;
                    end
                    S_ARG: begin
                        arg_q   <= i_data;
                        state_q <= S_CHK;
                    end
                    S_CHK: begin
                        state_q <= S_IDLE;
                        trig_q  <= frame_ok && cmd_q[4];
                        err_q   <= !frame_ok;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else if (gap_expire) begin
                state_q <= S_IDLE;
                err_q   <= 1'b1;
            end
        end
    end

    // Hold timer: an accept always wins over expiry and restarts the ms count from a fresh prescale.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dir_q   <= 4'd0;
            ms_q    <= 8'd0;
            presc_q <= '0;
        end else if (accept) begin
            dir_q   <= cmd_q[3:0];
            ms_q    <= ms_load_d;
            presc_q <= '0;
        end else if (ms_q != 8'd0) begin
            if (presc_q == PRE_MAX) begin
                presc_q <= '0;
                ms_q    <= ms_q - 8'd1;
            end else begin
                presc_q <= presc_q + PRE_W'(1);
            end
        end else begin
            dir_q <= 4'd0;
        end
    end

    assign o_right     = dir_q[0];
    assign o_left      = dir_q[1];
    assign o_up        = dir_q[2];
    assign o_down      = dir_q[3];
    assign o_trigger   = trig_q;
    assign o_frame_err = err_q;
    assign o_busy      = (state_q != S_IDLE);

endmodule
